// File: rtl/stream_checker.sv
// stream_checker: receives a countdown burst on an AXI-Stream sink and checks it.
// Lane A (TDATA[31:0]) must carry BEAT_COUNT..1 and lane B (TDATA[287:256]) must
// carry lane A minus 1. The block counts beats and mismatches and measures the
// cycles between the first and last accepted beats.
// Optional feature: define STREAM_CHECKER_ERR_CAPTURE_EN to capture the first
// mismatching beat on first_err; without it first_err is tied to zero.
module stream_checker #(
   parameter int unsigned BEAT_COUNT = 500
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         clear,
   input  logic [511:0] IN_AXIS_TDATA,
   input  logic         IN_AXIS_TVALID,
   output logic         IN_AXIS_TREADY,
   output logic         busy,
   output logic         done,
   output logic [31:0]  beats_rcvd,
   output logic [31:0]  error_count,
   output logic [63:0]  rx_time,
   output logic [95:0]  first_err
);

   localparam logic [31:0] BEAT_INIT = 32'(BEAT_COUNT);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic        armed_q, armed_d;
   logic        tready_q, tready_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [63:0] cycle_q, cycle_d;
   logic [63:0] start_q, start_d;
   logic [31:0] expected_q, expected_d;
   logic [31:0] beats_q, beats_d;
   logic [31:0] error_q, error_d;
   logic [63:0] rx_time_q, rx_time_d;

   logic [31:0] lane_a;
   logic [31:0] lane_b;
   logic [31:0] expected_cur;
   logic [63:0] start_cur;
   logic        accept;
   logic        mismatch;
   logic        last_beat;
   logic        unused_tdata;

   assign lane_a       = IN_AXIS_TDATA[31:0];
   assign lane_b       = IN_AXIS_TDATA[287:256];
   assign unused_tdata = ^{IN_AXIS_TDATA[511:288], IN_AXIS_TDATA[255:32]};

   // The first beat of a run is taken in IDLE, so its expectation and start
   // cycle come straight from the constant and the live counter.
   assign expected_cur = (state_q == IDLE) ? BEAT_INIT : expected_q;
   assign start_cur    = (state_q == IDLE) ? cycle_q : start_q;
   assign accept       = IN_AXIS_TVALID && tready_q && !clear;
   assign mismatch     = (lane_a != expected_cur) || (lane_b != (expected_cur - 32'd1));
   assign last_beat    = (expected_cur == 32'd1);

   // FSM state register
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (accept) state_d = last_beat ? DONE : RUN;
            RUN:     if (accept && last_beat) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM outputs, registered from the next state; armed_q delays the first
   // TREADY after reset by one edge, and clear forces one cycle of TREADY low.
   always_comb begin
      armed_d  = 1'b1;
      tready_d = armed_q && !clear && (state_d != DONE);
      busy_d   = (state_d == RUN);
      done_d   = (state_d == DONE);
   end

   // Datapath next values: cycle counter, countdown, statistics
   always_comb begin
      cycle_d    = cycle_q + 64'd1;
      start_d    = start_q;
      expected_d = expected_q;
      beats_d    = beats_q;
      error_d    = error_q;
      rx_time_d  = rx_time_q;
      if (clear) begin
         beats_d   = '0;
         error_d   = '0;
         rx_time_d = '0;
      end else if (accept) begin
         start_d    = start_cur;
         expected_d = expected_cur - 32'd1;
         beats_d    = beats_q + 32'd1;
         if (mismatch && (error_q != '1)) begin
            error_d = error_q + 32'd1;
         end
         if (last_beat) begin
            rx_time_d = cycle_q - start_cur;
         end
      end
   end

   // Control and datapath registers
   always_ff @(posedge clock) begin
      if (!resetn) begin
         armed_q    <= 1'b0;
         tready_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         cycle_q    <= '0;
         start_q    <= '0;
         expected_q <= BEAT_INIT;
         beats_q    <= '0;
         error_q    <= '0;
         rx_time_q  <= '0;
      end else begin
         armed_q    <= armed_d;
         tready_q   <= tready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         cycle_q    <= cycle_d;
         start_q    <= start_d;
         expected_q <= expected_d;
         beats_q    <= beats_d;
         error_q    <= error_d;
         rx_time_q  <= rx_time_d;
      end
   end

`ifdef STREAM_CHECKER_ERR_CAPTURE_EN
   logic [95:0] first_err_q, first_err_d;

   // Capture the first mismatch; error_q is still zero only for that one
   always_comb begin
      first_err_d = first_err_q;
      if (clear) begin
         first_err_d = '0;
      end else if (accept && mismatch && (error_q == '0)) begin
         first_err_d = {beats_q + 32'd1, lane_b, lane_a};
      end
   end

   // First-error capture register
   always_ff @(posedge clock) begin
      if (!resetn) begin
         first_err_q <= '0;
      end else begin
         first_err_q <= first_err_d;
      end
   end

   assign first_err = first_err_q;
`else
   assign first_err = '0;
`endif

   assign IN_AXIS_TREADY = tready_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign beats_rcvd     = beats_q;
   assign error_count    = error_q;
   assign rx_time        = rx_time_q;

endmodule

// File: tb/tb_stream_checker.sv
// Directed testbench for stream_checker: a BEAT_COUNT=500 instance for the
// burst scenarios and a BEAT_COUNT=1 instance for the single-beat case.
module tb_stream_checker;

   logic         clock;
   logic         resetn;
   logic         clear;
   logic [511:0] tdata;
   logic         tvalid;
   logic         tready;
   logic         busy;
   logic         done;
   logic [31:0]  beats_rcvd;
   logic [31:0]  error_count;
   logic [63:0]  rx_time;
   logic [95:0]  first_err;

   logic         clear1;
   logic [511:0] tdata1;
   logic         tvalid1;
   logic         tready1;
   logic         busy1;
   logic         done1;
   logic [31:0]  beats1;
   logic [31:0]  errors1;
   logic [63:0]  rx_time1;
   logic [95:0]  first_err1;

   int tests;
   int fails;

   stream_checker #(.BEAT_COUNT(500)) dut (
      .clock(clock), .resetn(resetn), .clear(clear),
      .IN_AXIS_TDATA(tdata), .IN_AXIS_TVALID(tvalid), .IN_AXIS_TREADY(tready),
      .busy(busy), .done(done), .beats_rcvd(beats_rcvd), .error_count(error_count),
      .rx_time(rx_time), .first_err(first_err)
   );

   stream_checker #(.BEAT_COUNT(1)) dut1 (
      .clock(clock), .resetn(resetn), .clear(clear1),
      .IN_AXIS_TDATA(tdata1), .IN_AXIS_TVALID(tvalid1), .IN_AXIS_TREADY(tready1),
      .busy(busy1), .done(done1), .beats_rcvd(beats1), .error_count(errors1),
      .rx_time(rx_time1), .first_err(first_err1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [511:0] make_beat(input logic [31:0] a, input logic [31:0] b);
      logic [511:0] d;
      d = {16{32'hA5A5_5A5A}};
      d[31:0]    = a;
      d[287:256] = b;
      return d;
   endfunction

   // Sends n countdown beats starting at 500; gap inserts an idle cycle after
   // each valid cycle; beat number bad_idx carries lane A = 0xDEAD.
   // Returns at the negedge after the last accepted beat with TVALID low.
   task automatic send_burst(input int n, input bit gap, input int bad_idx);
      int k;
      int cyc;
      bit v;
      logic [31:0] a;
      k   = 1;
      cyc = 0;
      v   = 1'b0;
      while (k <= n && cyc < 4 * n + 20) begin
         @(negedge clock);
         cyc++;
         v = gap ? ~v : 1'b1;
         a = 32'(500 - (k - 1));
         tdata  = make_beat((k == bad_idx) ? 32'h0000_DEAD : a, a - 32'd1);
         tvalid = v;
         if (v && tready) k++;
      end
      @(negedge clock);
      tvalid = 1'b0;
      if (k <= n) begin
         tests++;
         fails++;
         $display("FAIL burst_timeout: accepted %0d beats, required %0d", k - 1, n);
      end
   endtask

   task automatic pulse_clear();
      @(negedge clock);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      clear = 1'b0; tvalid = 1'b0; tdata = '0;
      clear1 = 1'b0; tvalid1 = 1'b0; tdata1 = '0;
      repeat (3) @(negedge clock);
      tests++; if (tready !== 1'b0) begin fails++; $display("FAIL reset_tready: got %b want 0", tready); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
      tests++; if (beats_rcvd !== 32'd0) begin fails++; $display("FAIL reset_beats: got %0d want 0", beats_rcvd); end
      tests++; if (error_count !== 32'd0) begin fails++; $display("FAIL reset_errors: got %0d want 0", error_count); end
      tests++; if (rx_time !== 64'd0) begin fails++; $display("FAIL reset_rx_time: got %0d want 0", rx_time); end
      tests++; if (first_err !== 96'd0) begin fails++; $display("FAIL reset_first_err: got %h want 0", first_err); end
      resetn = 1'b1;
      @(negedge clock);
      tests++; if (tready !== 1'b0) begin fails++; $display("FAIL tready_first_edge: got %b want 0", tready); end
      @(negedge clock);
      tests++; if (tready !== 1'b1) begin fails++; $display("FAIL tready_second_edge: got %b want 1", tready); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_clean_burst();
      send_burst(500, 1'b0, 0);
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL clean_done: got %b want 1", done); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL clean_busy: got %b want 0", busy); end
      tests++; if (beats_rcvd !== 32'd500) begin fails++; $display("FAIL clean_beats: got %0d want 500", beats_rcvd); end
      tests++; if (error_count !== 32'd0) begin fails++; $display("FAIL clean_errors: got %0d want 0", error_count); end
      tests++; if (rx_time !== 64'd499) begin fails++; $display("FAIL clean_rx_time: got %0d want 499", rx_time); end
      tests++; if (tready !== 1'b0) begin fails++; $display("FAIL clean_tready: got %b want 0", tready); end
      // DONE holds its statistics while the source keeps offering beats
      @(negedge clock);
      tvalid = 1'b1;
      tdata = make_beat(32'd5, 32'd4);
      repeat (3) @(negedge clock);
      tvalid = 1'b0;
      tests++; if (beats_rcvd !== 32'd500) begin fails++; $display("FAIL done_hold_beats: got %0d want 500", beats_rcvd); end
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL done_hold: got %b want 1", done); end
      pulse_clear();
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL clear_done: got %b want 0", done); end
      tests++; if (rx_time !== 64'd0) begin fails++; $display("FAIL clear_rx_time: got %0d want 0", rx_time); end
      @(negedge clock);
      tests++; if (tready !== 1'b1) begin fails++; $display("FAIL clear_tready_back: got %b want 1", tready); end
   endtask

   task automatic test_backpressure();
      send_burst(500, 1'b1, 0);
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL bp_done: got %b want 1", done); end
      tests++; if (beats_rcvd !== 32'd500) begin fails++; $display("FAIL bp_beats: got %0d want 500", beats_rcvd); end
      tests++; if (error_count !== 32'd0) begin fails++; $display("FAIL bp_errors: got %0d want 0", error_count); end
      tests++; if (rx_time !== 64'd998) begin fails++; $display("FAIL bp_rx_time: got %0d want 998", rx_time); end
      pulse_clear();
      @(negedge clock);
   endtask

   task automatic test_corruption();
      logic [95:0] exp_fe;
`ifdef STREAM_CHECKER_ERR_CAPTURE_EN
      exp_fe = {32'd7, 32'd493, 32'h0000_DEAD};
`else
      exp_fe = '0;
`endif
      send_burst(500, 1'b0, 7);
      tests++; if (error_count !== 32'd1) begin fails++; $display("FAIL corrupt_errors: got %0d want 1", error_count); end
      tests++; if (beats_rcvd !== 32'd500) begin fails++; $display("FAIL corrupt_beats: got %0d want 500", beats_rcvd); end
      tests++; if (first_err !== exp_fe) begin fails++; $display("FAIL corrupt_first_err: got %h want %h", first_err, exp_fe); end
      tests++; if (rx_time !== 64'd499) begin fails++; $display("FAIL corrupt_rx_time: got %0d want 499", rx_time); end
      pulse_clear();
      tests++; if (first_err !== 96'd0) begin fails++; $display("FAIL corrupt_clear_first_err: got %h want 0", first_err); end
      tests++; if (error_count !== 32'd0) begin fails++; $display("FAIL corrupt_clear_errors: got %0d want 0", error_count); end
      @(negedge clock);
   endtask

   task automatic test_clear_mid_run();
      send_burst(100, 1'b0, 0);
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b want 1", busy); end
      tests++; if (beats_rcvd !== 32'd100) begin fails++; $display("FAIL mid_beats: got %0d want 100", beats_rcvd); end
      // beat 101 offered in the same cycle as clear
      tdata  = make_beat(32'd400, 32'd399);
      tvalid = 1'b1;
      clear  = 1'b1;
      @(negedge clock);
      clear  = 1'b0;
      tvalid = 1'b0;
      tests++; if (beats_rcvd !== 32'd0) begin fails++; $display("FAIL midclr_beats: got %0d want 0", beats_rcvd); end
      tests++; if (error_count !== 32'd0) begin fails++; $display("FAIL midclr_errors: got %0d want 0", error_count); end
      tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL midclr_idle: busy/done got %b%b want 00", busy, done); end
      tests++; if (tready !== 1'b0) begin fails++; $display("FAIL midclr_tready_low: got %b want 0", tready); end
      @(negedge clock);
      tests++; if (tready !== 1'b1) begin fails++; $display("FAIL midclr_tready_back: got %b want 1", tready); end
      // a fresh burst must begin counting from BEAT_COUNT again
      send_burst(500, 1'b0, 0);
      tests++; if (error_count !== 32'd0) begin fails++; $display("FAIL after_clear_errors: got %0d want 0", error_count); end
      tests++; if (beats_rcvd !== 32'd500) begin fails++; $display("FAIL after_clear_beats: got %0d want 500", beats_rcvd); end
      pulse_clear();
      @(negedge clock);
   endtask

   task automatic test_reset_mid_run();
      send_burst(250, 1'b0, 0);
      resetn = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      tests++; if (beats_rcvd !== 32'd0) begin fails++; $display("FAIL rst_mid_beats: got %0d want 0", beats_rcvd); end
      tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rst_mid_state: busy/done got %b%b want 00", busy, done); end
      tests++; if (tready !== 1'b0) begin fails++; $display("FAIL rst_mid_tready: got %b want 0", tready); end
      tests++; if (rx_time !== 64'd0) begin fails++; $display("FAIL rst_mid_rx_time: got %0d want 0", rx_time); end
      @(negedge clock);
      tests++; if (tready !== 1'b0) begin fails++; $display("FAIL rst_mid_tready_edge1: got %b want 0", tready); end
      send_burst(500, 1'b0, 0);
      tests++; if (beats_rcvd !== 32'd500) begin fails++; $display("FAIL rst_fresh_beats: got %0d want 500", beats_rcvd); end
      tests++; if (error_count !== 32'd0) begin fails++; $display("FAIL rst_fresh_errors: got %0d want 0", error_count); end
      tests++; if (rx_time !== 64'd499) begin fails++; $display("FAIL rst_fresh_rx_time: got %0d want 499", rx_time); end
   endtask

   task automatic test_single_beat();
      @(negedge clock);
      tests++; if (tready1 !== 1'b1) begin fails++; $display("FAIL single_tready_idle: got %b want 1", tready1); end
      tdata1  = make_beat(32'd1, 32'd0);
      tvalid1 = 1'b1;
      @(negedge clock);
      tvalid1 = 1'b0;
      tests++; if (done1 !== 1'b1) begin fails++; $display("FAIL single_done: got %b want 1", done1); end
      tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL single_busy: got %b want 0", busy1); end
      tests++; if (rx_time1 !== 64'd0) begin fails++; $display("FAIL single_rx_time: got %0d want 0", rx_time1); end
      tests++; if (beats1 !== 32'd1) begin fails++; $display("FAIL single_beats: got %0d want 1", beats1); end
      tests++; if (errors1 !== 32'd0) begin fails++; $display("FAIL single_errors: got %0d want 0", errors1); end
      tests++; if (tready1 !== 1'b0) begin fails++; $display("FAIL single_tready: got %b want 0", tready1); end
      tests++; if (first_err1 !== 96'd0) begin fails++; $display("FAIL single_first_err: got %h want 0", first_err1); end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_clean_burst();
      test_backpressure();
      test_corruption();
      test_clear_mid_run();
      test_reset_mid_run();
      test_single_beat();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
